// File: rtl/fib_sequence_gen.sv
`default_nettype none
// ============================================================================
// Module   : fib_sequence_gen
// Purpose  : Free-running Fibonacci term generator that restarts from F(0)
//            when the next term would overflow WIDTH bits.
// Revision : 1.0
// ============================================================================
module fib_sequence_gen #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out,
  output logic [7:0]       idx,
  output logic             last,
  output logic             wrap
);

  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] nxt_q, nxt_d;
  logic [7:0]       idx_q, idx_d;
  logic             last_q, last_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   w_sum;

  // w_sum is the term following nxt_q; its carry flags nxt_q as the final term.
  always_comb begin
    w_sum  = {1'b0, cur_q} + {1'b0, nxt_q};
    cur_d  = nxt_q;
    nxt_d  = w_sum[WIDTH-1:0];
    idx_d  = idx_q + 8'd1;
    last_d = w_sum[WIDTH];
    wrap_d = 1'b0;
    if (last_q) begin
      cur_d  = '0;
      nxt_d  = {{(WIDTH-1){1'b0}}, 1'b1};
      idx_d  = 8'd0;
      last_d = 1'b0;
      wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_q  <= '0;
      nxt_q  <= {{(WIDTH-1){1'b0}}, 1'b1};
      idx_q  <= 8'd0;
      last_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      nxt_q  <= nxt_d;
      idx_q  <= idx_d;
      last_q <= last_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = cur_q;
  assign idx  = idx_q;
  assign last = last_q;
  assign wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_fib_sequence_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_fib_sequence_gen
// Purpose  : Checks 32-bit and 8-bit generators against a Fibonacci table model.
// Revision : 1.0
// ============================================================================
module tb_fib_sequence_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] out32;
  logic [7:0]  idx32;
  logic        last32, wrap32;
  logic [7:0]  out8;
  logic [7:0]  idx8;
  logic        last8, wrap8;

  int errors = 0;
  int checks = 0;

  longint unsigned fib [0:93];
  int  n32 = 0, n8 = 0;
  bit  w32 = 0, w8 = 0;
  int  lim32, lim8;
  int  since32 = -1;

  fib_sequence_gen #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .out(out32), .idx(idx32), .last(last32), .wrap(wrap32)
  );

  fib_sequence_gen #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .out(out8), .idx(idx8), .last(last8), .wrap(wrap8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int last_index(input int w);
    int n = 0;
    while (n < 93 && fib[n+1] < (64'd1 << w)) n++;
    return n;
  endfunction

  // One clock with rst held at r, then the reference model advances and is compared.
  task automatic step(input logic r);
    rst = r;
    @(posedge clk);
    if (!r) begin
      n32 = 0; w32 = 0; n8 = 0; w8 = 0; since32 = -1;
    end else begin
      if (n32 == lim32) begin n32 = 0; w32 = 1; end else begin n32++; w32 = 0; end
      if (n8 == lim8)   begin n8 = 0;  w8 = 1;  end else begin n8++;  w8 = 0;  end
      if (since32 >= 0) since32++;
      if (w32) begin
        if (since32 >= 0) chk("period32", since32, 48);
        since32 = 0;
      end
    end
    #1;
    chk("out32",  out32,  fib[n32]);
    chk("idx32",  idx32,  n32);
    chk("last32", last32, (n32 == lim32));
    chk("wrap32", wrap32, w32);
    chk("out8",   out8,   fib[n8]);
    chk("idx8",   idx8,   n8);
    chk("last8",  last8,  (n8 == lim8));
    chk("wrap8",  wrap8,  w8);
    case (n32)
      10: chk("F10", out32, 55);
      20: chk("F20", out32, 6765);
      30: chk("F30", out32, 832040);
      40: chk("F40", out32, 102334155);
      47: chk("F47", out32, 64'd2971215073);
      default: ;
    endcase
    if (n8 == 13) chk("F13_w8", out8, 233);
  endtask

  task automatic run_until(input int target);
    int budget = 200;
    while (n32 != target && budget > 0) begin
      step(1'b1);
      budget--;
    end
    if (n32 != target) chk("timeout", 0, 1);
  endtask

  initial begin
    fib[0] = 0;
    fib[1] = 1;
    for (int i = 2; i <= 93; i++) fib[i] = fib[i-1] + fib[i-2];
    lim32 = last_index(32);
    lim8  = last_index(8);

    // Reset held two edges, then release into 1,1,2,3,5,8,13.
    step(1'b0);
    step(1'b0);
    chk("rst_out", out32, 0);
    for (int i = 0; i < 7; i++) step(1'b1);
    chk("seq7", out32, 13);

    // Overflow restart and the periodic restart after it.
    run_until(47);
    chk("last_at47", last32, 1);
    step(1'b1);
    chk("wrap_pulse", wrap32, 1);
    for (int i = 0; i < 100; i++) step(1'b1);

    // Mid-run reset while out=21.
    run_until(8);
    chk("out21", out32, 21);
    step(1'b0);
    chk("midrst_wrap", wrap32, 0);
    for (int i = 0; i < 3; i++) step(1'b1);

    // Reset on the last-term cycle suppresses the wrap pulse.
    run_until(47);
    step(1'b0);
    chk("rst_on_last_wrap", wrap32, 0);
    chk("rst_on_last_idx", idx32, 0);

    // Random sparse reset pulses.
    for (int i = 0; i < 800; i++) step(($urandom_range(0, 49) != 0) ? 1'b1 : 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fib_sequence_gen.md
Name:
fib_sequence_gen

Overview:
- Free-running Fibonacci sequence generator. After reset release it emits one term per clock: F(0)=0, F(1)=1, F(n)=F(n-1)+F(n-2).
- When the next term would not fit in WIDTH bits, the generator restarts from F(0).
- Used as a self-contained stimulus/pattern source; its only inputs are clock and reset.

Parameters:
- WIDTH, 32, bit width of the term output; legal range 8..64.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-low (0 = reset asserted)
- out  output WIDTH  current Fibonacci term F(idx), registered
- idx  output 8  index n of the term currently on out, registered
- last  output 1  high while out holds the largest representable term (next term overflows)
- wrap  output 1  one-cycle pulse on the first cycle of each restarted sequence (not after reset)

Behaviour:
- Reset: clk and rst are fixed as stated above; polarity and synchronicity are not configurable.
  - Reset is sampled only at the rising clk edge. Asynchronous glitches on rst have no effect.
  - While rst==0 at a clock edge, the edge loads out=0, idx=0, last=0, wrap=0.
  - Internal next-term register is loaded with 1, i.e. the pair (F(0), F(1)).
- Run: every rising edge with rst==1 advances one term.
  - Latency 1 cycle per term: first edge after release gives out=1 (F(1)), idx=1.
  - Next edges give 1, 2, 3, 5, 8, ...
- Internal state: two WIDTH-bit registers, cur (=out) and nxt.
  - Per advance: cur <= nxt; nxt <= cur + nxt.
  - The sum is computed at WIDTH+1 bits.
- Overflow/restart:
  - When the WIDTH+1-bit sum needed for the term after nxt has its MSB set, nxt is the last representable term.
  - last is asserted in the cycle out equals that term.
  - On the following edge: out <= 0, idx <= 0, nxt <= 1, wrap <= 1. The sequence then continues 1, 1, 2, ... as after reset.
  - wrap deasserts on the next edge.
  - The sequence never outputs a truncated or wrapped sum.
- Boundary values:
  - WIDTH=32: last term is F(47)=2971215073 at idx=47. Full period is 48 cycles.
  - WIDTH=16: last term is F(24)=46368, period 25.
  - WIDTH=8: last term is F(13)=233, period 14.
- idx increments by 1 per advance and resets to 0 on restart. It never exceeds 93 (WIDTH=64 limit).
- Reset mid-sequence: a synchronous rst==0 at any edge (including a last or wrap cycle) overrides advance and restart.
  - The result is the reset state, with wrap=0.
- Holding rst==0 for multiple cycles keeps out=0, idx=0.
  - First advance occurs on the first edge with rst==1.
- All outputs are driven directly from flops; no combinational paths from rst to outputs.
- Power-up state before the first reset edge is undefined. The bench must apply reset.

Test Plan:
- Reset and release: hold rst=0 for 2 edges -> out=0, idx=0, wrap=0. Release -> successive edges give out=1,1,2,3,5,8,13 with idx=1..7.
- Known terms (WIDTH=32): after release, idx=10 -> out=55; idx=20 -> 6765; idx=30 -> 832040; idx=40 -> 102334155.
- Overflow restart (WIDTH=32): idx=47 -> out=2971215073 with last=1. Next edge -> out=0, idx=0, wrap=1, last=0. Next edge -> out=1, wrap=0. Second restart occurs exactly 48 cycles later.
- Small width (WIDTH=8): out reaches 233 at idx=13 with last=1, then restarts to 0 with wrap=1. out never exceeds 255 or shows 377 mod 256=121.
- Mid-run reset: drive rst=0 for one edge while out=21 -> out=0, idx=0, wrap=0. Release -> 1, 1, 2, ...
- Reset on restart cycle: assert rst=0 at the edge where out=F(47) -> out=0, idx=0, wrap=0, not a wrap pulse.
